// File: rtl/ndata_to_axi_packer.sv
// Typed ndata -> AXI4S packer: gathers 64/W consecutive NUM_ELEMENTS-lane beats of
// W-bit elements into one 64*NUM_ELEMENTS-bit word, flushing partial words on last.
module ndata_to_axi_packer #(
   parameter int NUM_ELEMENTS = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   // element type side channel (W in bits; anything but 8/16/32 means 64)
   input  logic                         type_valid_i,
   input  logic [6:0]                   type_width_i,
   output logic                         type_ready_o,
   // ndata input
   input  logic [64*NUM_ELEMENTS-1:0]   in_data_i,
   input  logic [NUM_ELEMENTS-1:0]      in_keep_i,
   input  logic                         in_last_i,
   input  logic                         in_valid_i,
   output logic                         in_ready_o,
   // AXI4S output
   output logic [64*NUM_ELEMENTS-1:0]   out_tdata_o,
   output logic [8*NUM_ELEMENTS-1:0]    out_tkeep_o,
   output logic                         out_tlast_o,
   output logic                         out_tvalid_o,
   input  logic                         out_tready_i,
   // beat counter state
   output logic [2:0]                   dbg_beat_cnt_o
);

   localparam int AXI_WIDTH = 64 * NUM_ELEMENTS;
   localparam int KEEP_WIDTH = AXI_WIDTH / 8;

   typedef enum logic [1:0] {
      WIDTH_8,
      WIDTH_16,
      WIDTH_32,
      WIDTH_64
   } width_e;

   width_e                  width_sel;
   logic [2:0]              last_slot;
   logic [2:0]              slot;
   logic                    is_final;
   logic                    out_free;
   logic                    accept;

   logic [2:0]              beat_cnt_q, beat_cnt_d;
   logic [AXI_WIDTH-1:0]    acc_data_q, acc_data_d;
   logic [KEEP_WIDTH-1:0]   acc_keep_q, acc_keep_d;
   logic [AXI_WIDTH-1:0]    out_tdata_q, out_tdata_d;
   logic [KEEP_WIDTH-1:0]   out_tkeep_q, out_tkeep_d;
   logic                    out_tlast_q, out_tlast_d;
   logic                    out_tvalid_q, out_tvalid_d;

   logic [AXI_WIDTH-1:0]    slot_data;
   logic [KEEP_WIDTH-1:0]   slot_keep;

   always_comb begin
      width_sel = WIDTH_64;
      last_slot = 3'd0;
      case (type_width_i)
         7'd8:    width_sel = WIDTH_8;
         7'd16:   width_sel = WIDTH_16;
         7'd32:   width_sel = WIDTH_32;
         default: width_sel = WIDTH_64;
      endcase
      case (width_sel)
         WIDTH_8:  last_slot = 3'd7;
         WIDTH_16: last_slot = 3'd3;
         WIDTH_32: last_slot = 3'd1;
         default:  last_slot = 3'd0;
      endcase
   end

   // Masking keeps the slot inside the word even if the type were changed mid-word.
   assign slot     = beat_cnt_q & last_slot;
   assign is_final = (slot == last_slot) || in_last_i;

   // Handshakes: a transfer happens on a rising clk edge where valid && ready.
   // Non-final beats only need a type; a final beat also needs a free output
   // register (empty, or being drained this same cycle). The type is consumed
   // together with the accepted last beat.
   assign out_free     = !out_tvalid_q || out_tready_i;
   assign in_ready_o   = type_valid_i && (is_final ? out_free : 1'b1);
   assign accept       = in_valid_i && in_ready_o;
   assign type_ready_o = in_valid_i && in_last_i && in_ready_o;

   always_comb begin
      slot_data = '0;
      slot_keep = '0;
      for (int i = 0; i < NUM_ELEMENTS; i++) begin
         case (width_sel)
            WIDTH_8: begin
               slot_data[(int'(slot) * NUM_ELEMENTS + i) * 8 +: 8] = in_data_i[i * 64 +: 8];
               slot_keep[int'(slot) * NUM_ELEMENTS + i]            = in_keep_i[i];
            end
            WIDTH_16: begin
               slot_data[(int'(slot) * NUM_ELEMENTS + i) * 16 +: 16] = in_data_i[i * 64 +: 16];
               slot_keep[(int'(slot) * NUM_ELEMENTS + i) * 2 +: 2]   = {2{in_keep_i[i]}};
            end
            WIDTH_32: begin
               slot_data[(int'(slot) * NUM_ELEMENTS + i) * 32 +: 32] = in_data_i[i * 64 +: 32];
               slot_keep[(int'(slot) * NUM_ELEMENTS + i) * 4 +: 4]   = {4{in_keep_i[i]}};
            end
            default: begin
               slot_data[i * 64 +: 64] = in_data_i[i * 64 +: 64];
               slot_keep[i * 8 +: 8]   = {8{in_keep_i[i]}};
            end
         endcase
      end
   end

   always_comb begin
      beat_cnt_d   = beat_cnt_q;
      acc_data_d   = acc_data_q;
      acc_keep_d   = acc_keep_q;
      out_tdata_d  = out_tdata_q;
      out_tkeep_d  = out_tkeep_q;
      out_tlast_d  = out_tlast_q;
      out_tvalid_d = out_tvalid_q;

      if (out_tready_i) begin
         out_tvalid_d = 1'b0;
      end

      if (accept) begin
         if (is_final) begin
            out_tdata_d  = acc_data_q | slot_data;
            out_tkeep_d  = acc_keep_q | slot_keep;
            out_tlast_d  = in_last_i;
            out_tvalid_d = 1'b1;
            acc_data_d   = '0;
            acc_keep_d   = '0;
            beat_cnt_d   = 3'd0;
         end else begin
            acc_data_d   = acc_data_q | slot_data;
            acc_keep_d   = acc_keep_q | slot_keep;
            beat_cnt_d   = slot + 3'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_cnt_q   <= 3'd0;
         acc_data_q   <= '0;
         acc_keep_q   <= '0;
         out_tdata_q  <= '0;
         out_tkeep_q  <= '0;
         out_tlast_q  <= 1'b0;
         out_tvalid_q <= 1'b0;
      end else begin
         beat_cnt_q   <= beat_cnt_d;
         acc_data_q   <= acc_data_d;
         acc_keep_q   <= acc_keep_d;
         out_tdata_q  <= out_tdata_d;
         out_tkeep_q  <= out_tkeep_d;
         out_tlast_q  <= out_tlast_d;
         out_tvalid_q <= out_tvalid_d;
      end
   end

   assign out_tdata_o    = out_tdata_q;
   assign out_tkeep_o    = out_tkeep_q;
   assign out_tlast_o    = out_tlast_q;
   assign out_tvalid_o   = out_tvalid_q;
   assign dbg_beat_cnt_o = beat_cnt_q;

endmodule

// File: tb/tb_ndata_to_axi_packer.sv
// Bench for ndata_to_axi_packer (NUM_ELEMENTS=4): directed steps plus random streams,
// checked against a word-level model of the packing rules.
module tb_ndata_to_axi_packer;

   localparam int N  = 4;
   localparam int AW = 64 * N;
   localparam int KW = AW / 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          type_valid_i = 1'b0;
   logic [6:0]    type_width_i = 7'd64;
   logic          type_ready_o;
   logic [AW-1:0] in_data_i = '0;
   logic [N-1:0]  in_keep_i = '0;
   logic          in_last_i = 1'b0;
   logic          in_valid_i = 1'b0;
   logic          in_ready_o;
   logic [AW-1:0] out_tdata_o;
   logic [KW-1:0] out_tkeep_o;
   logic          out_tlast_o;
   logic          out_tvalid_o;
   logic          out_tready_i = 1'b1;
   logic [2:0]    dbg_beat_cnt_o;

   ndata_to_axi_packer #(.NUM_ELEMENTS(N)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .type_valid_i   (type_valid_i),
      .type_width_i   (type_width_i),
      .type_ready_o   (type_ready_o),
      .in_data_i      (in_data_i),
      .in_keep_i      (in_keep_i),
      .in_last_i      (in_last_i),
      .in_valid_i     (in_valid_i),
      .in_ready_o     (in_ready_o),
      .out_tdata_o    (out_tdata_o),
      .out_tkeep_o    (out_tkeep_o),
      .out_tlast_o    (out_tlast_o),
      .out_tvalid_o   (out_tvalid_o),
      .out_tready_i   (out_tready_i),
      .dbg_beat_cnt_o (dbg_beat_cnt_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int hs_cnt   = 0;
   bit rand_done = 0;

   logic [AW-1:0] exp_data_q[$];
   logic [KW-1:0] exp_keep_q[$];
   logic          exp_last_q[$];
   logic [AW-1:0] cur_d_q[$];
   logic [N-1:0]  cur_k_q[$];

   task automatic check(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   function automatic int eff_width(input int w);
      if (w == 8 || w == 16 || w == 32) return w;
      return 64;
   endfunction

   function automatic logic [AW-1:0] rand_data();
      logic [AW-1:0] r;
      for (int j = 0; j < AW / 32; j++) r[j*32 +: 32] = $urandom;
      return r;
   endfunction

   // Model: collect accepted beats of the current word; a word is complete after
   // 64/W beats or on last, and is then laid out element by element.
   task automatic model_push(input int w, input logic [AW-1:0] d, input logic [N-1:0] k,
                             input logic last, output logic fin);
      int            we;
      logic [AW-1:0] ed;
      logic [KW-1:0] ek;
      logic [AW-1:0] bd;
      logic [N-1:0]  bk;
      we = eff_width(w);
      cur_d_q.push_back(d);
      cur_k_q.push_back(k);
      fin = (cur_d_q.size() == 64 / we) || last;
      if (fin) begin
         ed = '0;
         ek = '0;
         for (int s = 0; s < cur_d_q.size(); s++) begin
            bd = cur_d_q[s];
            bk = cur_k_q[s];
            for (int i = 0; i < N; i++) begin
               for (int b = 0; b < we; b++) ed[(s*N + i)*we + b] = bd[i*64 + b];
               for (int b = 0; b < we / 8; b++) ek[(s*N + i)*(we/8) + b] = bk[i];
            end
         end
         exp_data_q.push_back(ed);
         exp_keep_q.push_back(ek);
         exp_last_q.push_back(last);
         cur_d_q.delete();
         cur_k_q.delete();
      end
   endtask

   // Called at posedge+#1; returns at posedge+#1 after the beat is taken.
   task automatic send_beat(input int w, input logic [AW-1:0] d, input logic [N-1:0] k,
                            input logic last);
      logic got;
      logic fin;
      got = 1'b0;
      fin = 1'b0;
      type_valid_i = 1'b1;
      type_width_i = 7'(w);
      in_data_i    = d;
      in_keep_i    = k;
      in_last_i    = last;
      in_valid_i   = 1'b1;
      for (int c = 0; c < 300 && !got; c++) begin
         @(negedge clk);
         if (in_ready_o) begin
            got = 1'b1;
            if (type_ready_o) hs_cnt++;
            model_push(w, d, k, last, fin);
         end
         @(posedge clk);
         #1;
      end
      if (!got) check("accept_timeout", got, 1'b1);
      if (got && fin) check("latency_tvalid", out_tvalid_o, 1'b1);
      in_valid_i = 1'b0;
      if (last) type_valid_i = 1'b0;
   endtask

   task automatic send_stream(input int w, input int nb, input bit rnd_keep,
                              input logic [N-1:0] last_keep);
      logic [N-1:0] k;
      hs_cnt = 0;
      for (int b = 0; b < nb; b++) begin
         if (rnd_keep) k = N'($urandom_range(0, 2**N - 1));
         else k = (b == nb - 1) ? last_keep : '1;
         send_beat(w, rand_data(), k, b == nb - 1);
      end
      check("type_handshakes", hs_cnt, 1);
   endtask

   task automatic drain();
      for (int c = 0; c < 500 && exp_data_q.size() != 0; c++) @(posedge clk);
      #1;
      check("drain_empty", exp_data_q.size(), 0);
   endtask

   // Output monitor: transfers at negedge, plus hold-stable check while stalled.
   logic          prev_stall = 1'b0;
   logic [AW-1:0] prev_data;
   logic [KW-1:0] prev_keep;
   logic          prev_last;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_tvalid", out_tvalid_o, 1'b1);
            check("stall_tdata", out_tdata_o, prev_data);
            check("stall_tkeep", out_tkeep_o, prev_keep);
            check("stall_tlast", out_tlast_o, prev_last);
         end
         if (out_tvalid_o && out_tready_i) begin
            if (exp_data_q.size() == 0) begin
               check("unexpected_word", exp_data_q.size(), 1);
            end else begin
               check("tdata", out_tdata_o, exp_data_q.pop_front());
               check("tkeep", out_tkeep_o, exp_keep_q.pop_front());
               check("tlast", out_tlast_o, exp_last_q.pop_front());
            end
         end
         prev_stall = out_tvalid_o && !out_tready_i;
         prev_data  = out_tdata_o;
         prev_keep  = out_tkeep_o;
         prev_last  = out_tlast_o;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      int pick;
      // reset state
      #2;
      check("rst_tvalid", out_tvalid_o, 1'b0);
      check("rst_tdata", out_tdata_o, '0);
      check("rst_tkeep", out_tkeep_o, '0);
      check("rst_tlast", out_tlast_o, 1'b0);
      check("rst_cnt", dbg_beat_cnt_o, 3'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      in_valid_i = 1'b1;
      in_last_i  = 1'b1;
      #1;
      check("no_type_in_ready", in_ready_o, 1'b0);
      check("no_type_type_ready", type_ready_o, 1'b0);
      in_valid_i = 1'b0;
      in_last_i  = 1'b0;
      @(posedge clk);
      #1;

      // W=64, 3 beats, back-to-back words
      out_tready_i = 1'b1;
      send_stream(64, 3, 0, '1);
      drain();

      // W=32 with lanes 1..4 then 5..8
      hs_cnt = 0;
      send_beat(32, {64'd4, 64'd3, 64'd2, 64'd1}, 4'hF, 1'b0);
      send_beat(32, {64'd8, 64'd7, 64'd6, 64'd5}, 4'hF, 1'b1);
      check("w32_type_hs", hs_cnt, 1);
      drain();

      // W=8 partial flush, last beat keep 0011
      send_stream(8, 4, 0, 4'b0011);
      drain();

      // W=16 stream behind a stalled W=64 word
      out_tready_i = 1'b0;
      fork
         begin
            send_stream(64, 1, 0, '1);
            send_stream(16, 4, 0, '1);
         end
         begin
            repeat (12) @(posedge clk);
            #1;
            check("stall_cnt", dbg_beat_cnt_o, 3'd3);
            check("stall_in_ready", in_ready_o, 1'b0);
            out_tready_i = 1'b1;
         end
      join
      drain();

      // back-to-back W=32 (3 beats) then W=64 (1 beat)
      send_stream(32, 3, 0, '1);
      send_stream(64, 1, 0, '1);
      drain();

      // reset after one of two W=32 beats
      send_beat(32, rand_data(), 4'hF, 1'b0);
      check("pre_rst_cnt", dbg_beat_cnt_o, 3'(cur_d_q.size()));
      rst_n = 1'b0;
      cur_d_q.delete();
      cur_k_q.delete();
      type_valid_i = 1'b0;
      #1;
      check("mid_rst_tvalid", out_tvalid_o, 1'b0);
      check("mid_rst_cnt", dbg_beat_cnt_o, 3'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send_stream(32, 2, 0, '1);
      drain();

      // random streams with random backpressure; width 24 exercises the 64 fallback
      fork
         begin
            for (int s = 0; s < 25; s++) begin
               pick = $urandom_range(0, 4);
               case (pick)
                  0: w = 8;
                  1: w = 16;
                  2: w = 32;
                  3: w = 64;
                  default: w = 24;
               endcase
               send_stream(w, $urandom_range(1, 10), 1, '1);
            end
            rand_done = 1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk);
               #1;
               out_tready_i = ($urandom_range(0, 3) != 0);
            end
            out_tready_i = 1'b1;
         end
      join
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
